nbody_readback: RTL and testbench



---
 rtl/nbody_readback.sv | 186 ++++++++++++++++++
 tb/tb_nbody_readback.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbody_readback.sv
`default_nettype none
// ============================================================================
// nbody_readback : bus-master sequencer that polls nbody DONE, raises READ,
//                  streams {index, x, y} per body, then clears READ.
// Optional feature macro: NBODY_RB_TIMEOUT_EN (bounded DONE polling)
// Revision: 1.0
// ============================================================================
module nbody_readback #(
  parameter int ADDR_WIDTH      = 16,
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int READ_LATENCY    = 4,
  parameter int POLL_GAP        = 8,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BODY_ADDR_WIDTH:0]   n_bodies,
  output logic                       chipselect,
  output logic                       read,
  output logic                       write,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [63:0]                writedata,
  input  logic [63:0]                readdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BODY_ADDR_WIDTH-1:0] out_index,
  output logic [63:0]                out_x,
  output logic [63:0]                out_y,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout
);

  localparam int NW    = BODY_ADDR_WIDTH + 1;
  localparam int SEL_W = ADDR_WIDTH - BODY_ADDR_WIDTH;
  localparam int CMAX  = (READ_LATENCY > POLL_GAP) ? READ_LATENCY : POLL_GAP;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [SEL_W-1:0] SEL_DONE = SEL_W'(7'h40);
  localparam logic [SEL_W-1:0] SEL_READ = SEL_W'(7'h01);
  localparam logic [SEL_W-1:0] SEL_X    = SEL_W'(7'h41);
  localparam logic [SEL_W-1:0] SEL_Y    = SEL_W'(7'h42);
  localparam logic [NW-1:0]    MAX_N    = NW'(2**BODY_ADDR_WIDTH);

  if (READ_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("nbody_readback: READ_LATENCY and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_POLL_RD, S_POLL_WAIT, S_POLL_GAP, S_SET_RD,
    S_RDX, S_RDX_WAIT, S_RDY, S_RDY_WAIT, S_EMIT, S_CLR_RD, S_FIN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [NW-1:0] n, idx;
  logic          lat_last, gap_last, idx_last, tmo_take;

  assign lat_last  = (cnt == CW'(READ_LATENCY - 1));
  assign gap_last  = (cnt == CW'(POLL_GAP - 1));
  assign idx_last  = (idx == n - NW'(1));
  assign out_index = idx[BODY_ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    addr       = '0;
    writedata  = '0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_POLL_RD;
      end
      S_POLL_RD: begin
        chipselect = 1'b1;
        read       = 1'b1;
        addr       = {SEL_DONE, {BODY_ADDR_WIDTH{1'b0}}};
        state_nxt  = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (lat_last) begin
          if (readdata[0])        state_nxt = S_SET_RD;
          else if (POLL_GAP == 0) state_nxt = S_POLL_RD;
          else                    state_nxt = S_POLL_GAP;
        end
      end
      S_POLL_GAP: if (gap_last) state_nxt = S_POLL_RD;
      S_SET_RD: begin
        chipselect = 1'b1;
        write      = 1'b1;
        addr       = {SEL_READ, {BODY_ADDR_WIDTH{1'b0}}};
        writedata  = 64'd1;
        state_nxt  = (n == '0) ? S_CLR_RD : S_RDX;
      end
      S_RDX: begin
        chipselect = 1'b1;
        read       = 1'b1;
        addr       = {SEL_X, idx[BODY_ADDR_WIDTH-1:0]};
        state_nxt  = S_RDX_WAIT;
      end
      S_RDX_WAIT: if (lat_last) state_nxt = S_RDY;
      S_RDY: begin
        chipselect = 1'b1;
        read       = 1'b1;
        addr       = {SEL_Y, idx[BODY_ADDR_WIDTH-1:0]};
        state_nxt  = S_RDY_WAIT;
      end
      S_RDY_WAIT: if (lat_last) state_nxt = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = idx_last ? S_CLR_RD : S_RDX;
      end
      S_CLR_RD: begin
        chipselect = 1'b1;
        write      = 1'b1;
        addr       = {SEL_READ, {BODY_ADDR_WIDTH{1'b0}}};
        state_nxt  = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // An expired poll budget abandons the frame without touching READ
    if (tmo_take) state_nxt = S_FIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n     <= '0;
      idx   <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      if (state == S_IDLE && start) n <= (n_bodies > MAX_N) ? MAX_N : n_bodies;
      if (state == S_SET_RD) idx <= '0;
      if (state == S_RDX_WAIT && lat_last) out_x <= readdata;
      if (state == S_RDY_WAIT && lat_last) out_y <= readdata;
      if (state == S_EMIT && out_ready && !idx_last) idx <= idx + NW'(1);
    end
  end

`ifdef NBODY_RB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          timeout_q, in_poll, done_seen;

  assign in_poll   = (state == S_POLL_RD) || (state == S_POLL_WAIT) || (state == S_POLL_GAP);
  assign done_seen = (state == S_POLL_WAIT) && lat_last && readdata[0];
  assign tmo_take  = in_poll && !done_seen && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) tcnt <= '0;
      else if (in_poll)             tcnt <= tcnt + 1'b1;
      if (tmo_take) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_take = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nbody_readback.sv
`default_nettype none
// ============================================================================
// tb_nbody_readback : randomized bench with an nbody slave model and a
//                     transaction-level expectation of each frame.
// Revision: 1.0
// ============================================================================
module tb_nbody_readback;
  localparam int AW = 16, BW = 9, LAT = 4, GAP = 8, TMO = 200;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [BW:0]   n_bodies = '0;
  logic          chipselect, read, write, out_valid, busy, done, timeout;
  logic          out_ready = 1'b0;
  logic [AW-1:0] addr;
  logic [63:0]   writedata, readdata, out_x, out_y;
  logic [BW-1:0] out_index;

  always #5 clk = ~clk;

  nbody_readback #(.ADDR_WIDTH(AW), .BODY_ADDR_WIDTH(BW), .READ_LATENCY(LAT),
                   .POLL_GAP(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies),
    .chipselect(chipselect), .read(read), .write(write), .addr(addr),
    .writedata(writedata), .readdata(readdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .timeout(timeout));

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct { int cyc; logic [63:0] data; } resp_t;
  typedef struct { int cyc; bit rd; bit wr; logic [AW-1:0] addr; logic [63:0] wd; } txn_t;
  typedef struct { logic [BW-1:0] idx; logic [63:0] x; logic [63:0] y; } beat_t;

  // Slave configuration (owned by the stimulus process)
  logic [63:0] x_mem [512];
  logic [63:0] y_mem [512];
  int done_zeros = 0, done_base = 0, stall_cfg = 0;
  bit done_stuck = 1'b0;

  // Observations (owned by the monitor)
  resp_t resp_q[$];
  txn_t  txn_q[$];
  beat_t beat_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, done_reads = 0, viol = 0, stall_cnt = 0;
  bit hold_valid = 1'b0;
  beat_t held;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    txn_t t;
    beat_t b;
    logic [63:0] d;
    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      readdata = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      readdata = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE;
    end
    if (!rst) begin
      if (chipselect) begin
        t.cyc = cyc; t.rd = read; t.wr = write; t.addr = addr; t.wd = writedata;
        txn_q.push_back(t);
        if (read == write) viol++;
        if (read) begin
          case (addr[AW-1:BW])
            7'h40: begin
              d = (done_stuck || (done_reads - done_base) < done_zeros) ? 64'd0 : 64'd1;
              done_reads++;
            end
            7'h41:   d = x_mem[addr[BW-1:0]];
            7'h42:   d = y_mem[addr[BW-1:0]];
            default: d = 64'hDEAD_BEEF;
          endcase
          resp_q.push_back('{cyc + LAT, d});
        end
      end else if (read || write || addr != '0 || writedata != '0) begin
        viol++;
      end
      if (out_valid && chipselect) viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) viol++;
      end
      if (hold_valid && out_valid &&
          (out_index != held.idx || out_x != held.x || out_y != held.y)) viol++;
      hold_valid = 1'b0;
      if (out_valid) begin
        b.idx = out_index; b.x = out_x; b.y = out_y;
        if (stall_cnt < stall_cfg) begin
          out_ready = 1'b0;
          stall_cnt++;
          hold_valid = 1'b1;
          held = b;
        end else begin
          out_ready = 1'b1;
          beat_q.push_back(b);
          stall_cnt = 0;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {60'd0, chipselect, read, write, out_valid}
               | {63'd0, |addr} | {63'd0, |writedata} | {63'd0, |out_index}
               | {63'd0, |out_x} | {63'd0, |out_y} | {61'd0, busy, done, timeout}, 64'd0);
  endtask

  task automatic run_frame(input int nb, input int zeros, input int stall,
                           input bit basic, input bit exp_tmo);
    int   tb0, bb0, db0, v0, nn, bad, polls;
    bit   got;
    txn_t e;
    txn_t exp_q[$];
    nn = (nb > 512) ? 512 : nb;
    for (int i = 0; i < 512; i++) begin
      x_mem[i] = {$urandom, $urandom};
      y_mem[i] = {$urandom, $urandom};
    end
    if (basic) begin
      x_mem[0] = 64'h3FF0000000000000; y_mem[0] = 64'h4024000000000000;
      x_mem[1] = 64'hC014000000000000; y_mem[1] = 64'hC02E000000000000;
      x_mem[2] = 64'h4034000000000000; y_mem[2] = 64'h0000000000000000;
    end
    done_zeros = zeros; done_base = done_reads; stall_cfg = stall;
    tb0 = txn_q.size(); bb0 = beat_q.size(); db0 = done_cnt; v0 = viol;
    n_bodies = (BW+1)'(nb); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    n_bodies = (BW+1)'($urandom); start = 1'b1;   // arrives while busy
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20000 && !got; k++) begin
      tick();
      if (done_cnt != db0) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    repeat (4) tick();

    polls = zeros + 1;
    e.cyc = 0;
    for (int p = 0; p < polls; p++) begin
      e.rd = 1; e.wr = 0; e.addr = {7'h40, 9'd0}; e.wd = 0; exp_q.push_back(e);
    end
    e.rd = 0; e.wr = 1; e.addr = {7'h01, 9'd0}; e.wd = 64'd1; exp_q.push_back(e);
    for (int i = 0; i < nn; i++) begin
      e.rd = 1; e.wr = 0; e.wd = 0;
      e.addr = {7'h41, BW'(i)}; exp_q.push_back(e);
      e.addr = {7'h42, BW'(i)}; exp_q.push_back(e);
    end
    e.rd = 0; e.wr = 1; e.addr = {7'h01, 9'd0}; e.wd = 64'd0; exp_q.push_back(e);

    check("txn_count", 64'(txn_q.size() - tb0), 64'(exp_q.size()));
    bad = 0;
    for (int k = 0; k < exp_q.size() && tb0 + k < txn_q.size(); k++)
      if (txn_q[tb0+k].rd != exp_q[k].rd || txn_q[tb0+k].wr != exp_q[k].wr ||
          txn_q[tb0+k].addr != exp_q[k].addr || txn_q[tb0+k].wd != exp_q[k].wd) bad++;
    check("txn_order", 64'(bad), 64'd0);
    bad = 0;
    for (int k = 1; k < polls && tb0 + k < txn_q.size(); k++)
      if (txn_q[tb0+k].cyc - txn_q[tb0+k-1].cyc != 1 + LAT + GAP) bad++;
    check("poll_spacing", 64'(bad), 64'd0);

    check("beat_count", 64'(beat_q.size() - bb0), 64'(nn));
    bad = 0;
    for (int i = 0; i < nn && bb0 + i < beat_q.size(); i++)
      if (beat_q[bb0+i].idx != BW'(i) || beat_q[bb0+i].x != x_mem[i] ||
          beat_q[bb0+i].y != y_mem[i]) bad++;
    check("beat_data", 64'(bad), 64'd0);
    if (basic && beat_q.size() > bb0 + 2) begin
      check("basic_x0", beat_q[bb0].x,   64'h3FF0000000000000);
      check("basic_y0", beat_q[bb0].y,   64'h4024000000000000);
      check("basic_x1", beat_q[bb0+1].x, 64'hC014000000000000);
      check("basic_y2", beat_q[bb0+2].y, 64'h0000000000000000);
    end
    if (nn > 1 && beat_q.size() > bb0) check("last_index", 64'(beat_q[$].idx), 64'(nn - 1));
    check("done_pulses", 64'(done_cnt - db0), 64'd1);
    check("bus_stream_rules", 64'(viol - v0), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("timeout_flag", 64'(timeout), 64'(exp_tmo));
  endtask

  initial begin
    int t0, db0, sc, wr;
    bit got;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();

    run_frame(3, 2, 0, 1'b1, 1'b0);
    run_frame(3, 2, 10, 1'b1, 1'b0);
    run_frame(0, 1, 0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      run_frame($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);

    // Reset in the middle of the Y read of a 3-body frame
    done_zeros = 0; done_base = done_reads; stall_cfg = 0;
    n_bodies = 10'd3; start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      tick();
      if (txn_q.size() > 0 && txn_q[$].addr[AW-1:BW] == 7'h42) got = 1'b1;
    end
    check("reached_rdy", 64'(got), 64'd1);
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check_all_zero("midframe_reset_outputs");
    repeat (4) tick();
    rst = 1'b0;
    t0 = txn_q.size();
    tick();
    check_all_zero("post_reset_outputs");
    repeat (30) tick();
    check("post_reset_quiet", 64'(txn_q.size() - t0), 64'd0);

    run_frame(512, 0, 0, 1'b0, 1'b0);
    run_frame(1000, 1, 1, 1'b0, 1'b0);

`ifdef NBODY_RB_TIMEOUT_EN
    done_stuck = 1'b1; stall_cfg = 0;
    t0 = txn_q.size(); db0 = done_cnt;
    n_bodies = 10'd3; start = 1'b1; sc = cyc;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      tick();
      if (done_cnt != db0) got = 1'b1;
    end
    check("tmo_done", 64'(got), 64'd1);
    check("tmo_latency", 64'((done_cyc - sc) <= TMO + LAT + GAP), 64'd1);
    check("tmo_flag", 64'(timeout), 64'd1);
    wr = 0;
    for (int k = t0; k < txn_q.size(); k++) if (txn_q[k].wr) wr++;
    check("tmo_no_write", 64'(wr), 64'd0);
    repeat (10) tick();
    done_stuck = 1'b0;
    run_frame(3, 0, 0, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
